// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//
// Multi-cycle control unit for the RV32I core. Each instruction moves through
// FETCH -> DECODE -> EXEC -> (MEM | MULDIV) -> WB. Instruction and data memory
// use req/ack handshakes. The unit drives the datapath control encodings and
// counts retired instructions.
//
// Optional feature: define MULDIV_EN to add the MULDIV state, its latency
// counter and the MULDIV_LAT parameter. When it is defined, an R-type with
// funct7_0=1 goes through MULDIV. Without it, funct7_0 is ignored and
// muldiv_busy is tied low.
//
// Parameters:
//   MULDIV_LAT  execute cycles of a MUL/DIV op (>=1), MULDIV_EN builds only
//   CNT_W       width of the retire counter
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   opcode, funct7_0    instruction[6:0] and instruction[25] from the IR
//   imem_req/imem_ack   instruction fetch handshake
//   dmem_req/dmem_ack   data access handshake
//   ir_we, pc_we        IR load strobe and PC update strobe
//   alu_op .. branch    registered datapath control encodings
//   mem_read/mem_write  load or store in progress (MEM state only)
//   reg_write           register file write strobe (WB state only)
//   muldiv_busy         MUL/DIV executing
//   illegal, retire     unsupported-opcode pulse, instruction-complete pulse
//   retire_cnt          retired-instruction count, wraps to zero
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
`ifdef MULDIV_EN
  parameter int MULDIV_LAT = 4,
`endif
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             funct7_0,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  input  logic             dmem_ack,
  output logic             ir_we,
  output logic             pc_we,
  output logic [2:0]       alu_op,
  output logic             alu_src,
  output logic             pc_to_reg_src,
  output logic [2:0]       imm_type,
  output logic             rd_src,
  output logic             mem_to_reg,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       branch,
  output logic             muldiv_busy,
  output logic             illegal,
  output logic             retire,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
`ifdef MULDIV_EN
    , MULDIV = 3'd5
`endif
  } state_t;

  // Instruction classes that steer the sequencing after DECODE.
  typedef enum logic [2:0] {
    CL_ILLEGAL = 3'd0,
    CL_RTYPE   = 3'd1,
    CL_LOAD    = 3'd2,
    CL_STORE   = 3'd3,
    CL_BRANCH  = 3'd4,
    CL_OTHER   = 3'd5
  } cls_t;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src;
    logic       pc_to_reg_src;
    logic [2:0] imm_type;
    logic       rd_src;
    logic       mem_to_reg;
    logic [1:0] branch;
  } ctl_t;

  // Reset and unsupported-opcode value of the decode outputs.
  localparam ctl_t CTL_DEFAULT = '{
    alu_op: 3'd4, alu_src: 1'b0, pc_to_reg_src: 1'b0, imm_type: 3'd0,
    rd_src: 1'b0, mem_to_reg: 1'b0, branch: 2'd0
  };

  // Map an opcode to the class that selects its path through the FSM.
  function automatic cls_t classify(input logic [6:0] op);
    cls_t c;
    case (op)
      7'b0110011: c = CL_RTYPE;
      7'b0000011: c = CL_LOAD;
      7'b0100011: c = CL_STORE;
      7'b1100011: c = CL_BRANCH;
      7'b0010011, 7'b1100111, 7'b0010111,
      7'b0110111, 7'b1101111: c = CL_OTHER;
      default:    c = CL_ILLEGAL;
    endcase
    return c;
  endfunction

  // Datapath control encodings for each supported opcode. Only R-type and
  // branch take rs2 as the ALU source; only loads write back memory data.
  function automatic ctl_t decode_ctl(input logic [6:0] op);
    ctl_t c;
    c = CTL_DEFAULT;
    case (op)
      7'b0110011: begin // R-type
        c.alu_op = 3'd0; c.alu_src = 1'b1; c.imm_type = 3'd5; c.mem_to_reg = 1'b1;
      end
      7'b0000011: begin // load
        c.alu_op = 3'd4; c.imm_type = 3'd0; c.mem_to_reg = 1'b0;
      end
      7'b0010011: begin // I-arith
        c.alu_op = 3'd1; c.imm_type = 3'd0; c.mem_to_reg = 1'b1;
      end
      7'b1100111: begin // JALR
        c.alu_op = 3'd4; c.imm_type = 3'd0; c.rd_src = 1'b1;
        c.mem_to_reg = 1'b1; c.branch = 2'd1;
      end
      7'b0100011: begin // store
        c.alu_op = 3'd4; c.imm_type = 3'd1; c.mem_to_reg = 1'b1;
      end
      7'b1100011: begin // branch
        c.alu_op = 3'd2; c.alu_src = 1'b1; c.pc_to_reg_src = 1'b1;
        c.imm_type = 3'd2; c.rd_src = 1'b1; c.mem_to_reg = 1'b1; c.branch = 2'd2;
      end
      7'b0010111: begin // AUIPC
        c.alu_op = 3'd4; c.pc_to_reg_src = 1'b1; c.imm_type = 3'd3;
        c.rd_src = 1'b1; c.mem_to_reg = 1'b1;
      end
      7'b0110111: begin // LUI
        c.alu_op = 3'd3; c.imm_type = 3'd3; c.mem_to_reg = 1'b1;
      end
      7'b1101111: begin // JAL
        c.alu_op = 3'd4; c.imm_type = 3'd4; c.rd_src = 1'b1;
        c.mem_to_reg = 1'b1; c.branch = 2'd3;
      end
      default: c = CTL_DEFAULT;
    endcase
    return c;
  endfunction

  state_t           state_r, next_state_s;
  cls_t             cls_r, op_cls_s;
  ctl_t             ctl_r;
  logic             imem_req_r, dmem_req_r, mem_read_r, mem_write_r, reg_write_r;
  logic             ir_we_s, pc_we_s, retire_s, illegal_s;
  logic [CNT_W-1:0] retire_cnt_r;

  assign op_cls_s = classify(opcode);

`ifdef MULDIV_EN
  localparam int MD_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
  logic [MD_W-1:0] md_cnt_r;
  logic            muldiv_busy_r;
`else
  // funct7_0 has no function in this build.
  logic unused_s;
  assign unused_s = funct7_0;
`endif

  // Next-state and handshake-dependent strobes. Strobes that react to an ack
  // or to the freshly loaded opcode must be combinational to land in the
  // same cycle.
  always_comb begin
    next_state_s = state_r;
    ir_we_s      = 1'b0;
    pc_we_s      = 1'b0;
    retire_s     = 1'b0;
    illegal_s    = 1'b0;
    case (state_r)
      FETCH: begin
        // imem_req_r gates the ack so the idle cycle after reset ignores it.
        if (imem_req_r && imem_ack) begin
          ir_we_s      = 1'b1;
          next_state_s = DECODE;
        end else begin
          next_state_s = FETCH;
        end
      end
      DECODE: begin
        if (op_cls_s == CL_ILLEGAL) begin
          illegal_s    = 1'b1;
          pc_we_s      = 1'b1;
          next_state_s = FETCH;
        end else begin
          next_state_s = EXEC;
        end
      end
      EXEC: begin
        case (cls_r)
          CL_LOAD, CL_STORE: next_state_s = MEM;
          CL_BRANCH: begin
            pc_we_s      = 1'b1;
            retire_s     = 1'b1;
            next_state_s = FETCH;
          end
`ifdef MULDIV_EN
          CL_RTYPE: begin
            if (funct7_0) begin
              next_state_s = MULDIV;
            end else begin
              next_state_s = WB;
            end
          end
`endif
          default: next_state_s = WB;
        endcase
      end
      MEM: begin
        if (dmem_ack) begin
          if (cls_r == CL_STORE) begin
            pc_we_s      = 1'b1;
            retire_s     = 1'b1;
            next_state_s = FETCH;
          end else begin
            next_state_s = WB;
          end
        end else begin
          next_state_s = MEM;
        end
      end
`ifdef MULDIV_EN
      MULDIV: begin
        if (md_cnt_r == '0) begin
          next_state_s = WB;
        end else begin
          next_state_s = MULDIV;
        end
      end
`endif
      WB: begin
        pc_we_s      = 1'b1;
        retire_s     = 1'b1;
        next_state_s = FETCH;
      end
      default: next_state_s = FETCH;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Decode registers: captured once in DECODE, held until the next DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_r <= CTL_DEFAULT;
      cls_r <= CL_ILLEGAL;
    end else if (state_r == DECODE) begin
      ctl_r <= decode_ctl(opcode);
      cls_r <= op_cls_s;
    end else begin
      ctl_r <= ctl_r;
      cls_r <= cls_r;
    end
  end

  // Per-state level outputs, registered from the next state so they are low
  // during reset and drop the cycle after the terminating ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_req_r  <= 1'b0;
      dmem_req_r  <= 1'b0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      reg_write_r <= 1'b0;
    end else begin
      imem_req_r  <= (next_state_s == FETCH);
      dmem_req_r  <= (next_state_s == MEM);
      mem_read_r  <= (next_state_s == MEM) && (cls_r == CL_LOAD);
      mem_write_r <= (next_state_s == MEM) && (cls_r == CL_STORE);
      reg_write_r <= (next_state_s == WB);
    end
  end

`ifdef MULDIV_EN
  // MUL/DIV latency counter: loads LAT-1 on entry, leaves at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_r <= '0;
    end else if ((state_r == EXEC) && (next_state_s == MULDIV)) begin
      md_cnt_r <= MD_W'(MULDIV_LAT - 1);
    end else if ((state_r == MULDIV) && (md_cnt_r != '0)) begin
      md_cnt_r <= md_cnt_r - MD_W'(1'b1);
    end else begin
      md_cnt_r <= md_cnt_r;
    end
  end

  // Busy flag for the MULDIV state; cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      muldiv_busy_r <= 1'b0;
    end else begin
      muldiv_busy_r <= (next_state_s == MULDIV);
    end
  end

  assign muldiv_busy = muldiv_busy_r;
`else
  assign muldiv_busy = 1'b0;
`endif

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_r <= '0;
    end else if (retire_s) begin
      retire_cnt_r <= retire_cnt_r + CNT_W'(1'b1);
    end else begin
      retire_cnt_r <= retire_cnt_r;
    end
  end

  assign imem_req      = imem_req_r;
  assign dmem_req      = dmem_req_r;
  assign mem_read      = mem_read_r;
  assign mem_write     = mem_write_r;
  assign reg_write     = reg_write_r;
  assign ir_we         = ir_we_s;
  assign pc_we         = pc_we_s;
  assign retire        = retire_s;
  assign illegal       = illegal_s;
  assign retire_cnt    = retire_cnt_r;
  assign alu_op        = ctl_r.alu_op;
  assign alu_src       = ctl_r.alu_src;
  assign pc_to_reg_src = ctl_r.pc_to_reg_src;
  assign imm_type      = ctl_r.imm_type;
  assign rd_src        = ctl_r.rd_src;
  assign mem_to_reg    = ctl_r.mem_to_reg;
  assign branch        = ctl_r.branch;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Drives directed and random instruction streams with random handshake
// delays into multicycle_ctrl. A per-instruction timeline model (cycle offsets
// derived from the handshake delays) and an opcode table give the expected
// outputs for every cycle. CNT_W=4 so the retire counter wraps.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam int CNT_W = 4;
`ifdef MULDIV_EN
  localparam int LAT = 4;
`endif
  localparam logic [11:0] DEC_DEF = {3'd4, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [6:0]       opcode;
  logic             funct7_0;
  logic             imem_req, imem_ack, dmem_req, dmem_ack;
  logic             ir_we, pc_we, alu_src, pc_to_reg_src, rd_src, mem_to_reg;
  logic             mem_read, mem_write, reg_write, muldiv_busy, illegal, retire;
  logic [2:0]       alu_op, imm_type;
  logic [1:0]       branch;
  logic [CNT_W-1:0] retire_cnt;
  logic [31:0]      ir_q = 32'h0;

  int          n_vec = 0;
  int          n_err = 0;
  int          cnt_m = 0;
  logic [11:0] dec_prev = DEC_DEF;

  assign opcode   = ir_q[6:0];
  assign funct7_0 = ir_q[25];

  always #5 clk = ~clk;

  multicycle_ctrl #(
`ifdef MULDIV_EN
    .MULDIV_LAT(LAT),
`endif
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct7_0(funct7_0),
    .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .ir_we(ir_we), .pc_we(pc_we), .alu_op(alu_op), .alu_src(alu_src),
    .pc_to_reg_src(pc_to_reg_src), .imm_type(imm_type), .rd_src(rd_src),
    .mem_to_reg(mem_to_reg), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .branch(branch), .muldiv_busy(muldiv_busy),
    .illegal(illegal), .retire(retire), .retire_cnt(retire_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Opcode table: {alu_op, alu_src, pc_to_reg_src, imm_type, rd_src, mem_to_reg, branch}.
  function automatic logic [11:0] exp_dec(input logic [6:0] op);
    case (op)
      7'b0110011: return {3'd0, 1'b1, 1'b0, 3'd5, 1'b0, 1'b1, 2'd0};
      7'b0000011: return {3'd4, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0};
      7'b0010011: return {3'd1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 2'd0};
      7'b1100111: return {3'd4, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 2'd1};
      7'b0100011: return {3'd4, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 2'd0};
      7'b1100011: return {3'd2, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 2'd2};
      7'b0010111: return {3'd4, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 2'd0};
      7'b0110111: return {3'd3, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 2'd0};
      7'b1101111: return {3'd4, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 2'd3};
      default:    return DEC_DEF;
    endcase
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return (op == 7'b0110011) || (op == 7'b0000011) || (op == 7'b0010011) ||
           (op == 7'b1100111) || (op == 7'b0100011) || (op == 7'b1100011) ||
           (op == 7'b0010111) || (op == 7'b0110111) || (op == 7'b1101111);
  endfunction

  function automatic logic [31:0] rand_word();
    logic [6:0]  ops [0:8];
    logic [31:0] w;
    ops = '{7'b0110011, 7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011,
            7'b1100011, 7'b0010111, 7'b0110111, 7'b1101111};
    w = $urandom;
    if ($urandom_range(0, 9) == 0) begin
      // Opcodes with low bits other than 2'b11 are never legal.
      w[6:0] = {5'($urandom), 2'($urandom_range(0, 2))};
    end else begin
      w[6:0] = ops[$urandom_range(0, 8)];
    end
    return w;
  endfunction

  // Applies one instruction; di/dd are fetch/data ack delays. abort >= 0
  // asserts reset in that cycle and ends the instruction there.
  task automatic run_instr(input logic [31:0] word, input int di, input int dd, input int abort);
    logic [6:0]  op;
    logic [11:0] dec_now;
    bit          is_ld, is_st, is_br, is_ill, is_mem;
    int          d, e, mack, wb, fin, lat_md, md_end;
    op     = word[6:0];
    is_ld  = (op == 7'b0000011);
    is_st  = (op == 7'b0100011);
    is_br  = (op == 7'b1100011);
    is_ill = !is_legal(op);
    is_mem = is_ld || is_st;
    lat_md = 0;
`ifdef MULDIV_EN
    if ((op == 7'b0110011) && word[25]) lat_md = LAT;
`endif
    d      = di + 1;
    e      = d + 1;
    mack   = e + 1 + dd;
    md_end = e + lat_md;
    wb     = -1;
    if (is_ill) fin = d;
    else if (is_br) fin = e;
    else if (is_st) fin = mack;
    else if (is_ld) begin wb = mack + 1; fin = wb; end
    else if (lat_md > 0) begin wb = md_end + 1; fin = wb; end
    else begin wb = e + 1; fin = wb; end
    dec_now = is_ill ? DEC_DEF : exp_dec(op);

    for (int t = 0; t <= fin; t++) begin
      imem_ack = (t == di) ? 1'b1 : ((t > di) ? 1'($urandom_range(0, 1)) : 1'b0);
      if (is_mem && (t == mack)) dmem_ack = 1'b1;
      else if (is_mem && (t > e) && (t < mack)) dmem_ack = 1'b0;
      else dmem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_val("imem_req", imem_req, t <= di);
      check_val("ir_we", ir_we, t == di);
      check_val("illegal", illegal, is_ill && (t == d));
      check_val("pc_we", pc_we, t == fin);
      check_val("retire", retire, (t == fin) && !is_ill);
      check_val("reg_write", reg_write, t == wb);
      check_val("dmem_req", dmem_req, is_mem && (t > e) && (t <= mack));
      check_val("mem_read", mem_read, is_ld && (t > e) && (t <= mack));
      check_val("mem_write", mem_write, is_st && (t > e) && (t <= mack));
      check_val("muldiv_busy", muldiv_busy, (t > e) && (t <= md_end));
      check_val("decode", {alu_op, alu_src, pc_to_reg_src, imm_type, rd_src, mem_to_reg, branch},
                (t > d) ? dec_now : dec_prev);
      check_val("retire_cnt", retire_cnt, cnt_m);
      if (t == abort) begin
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_val("abort_dmem_req", dmem_req, 0);
        check_val("abort_mem_read", mem_read, 0);
        check_val("abort_busy", muldiv_busy, 0);
        check_val("abort_retire_cnt", retire_cnt, 0);
        cnt_m    = 0;
        dec_prev = DEC_DEF;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("release_imem_req", imem_req, 0);
        check_val("release_retire", retire, 0);
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
      if (t == di) ir_q = word;
      if ((t == fin) && !is_ill) cnt_m = (cnt_m + 1) % (1 << CNT_W);
    end
    dec_prev = dec_now;
  endtask

  initial begin
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_imem_req", imem_req, 0);
    check_val("rst_alu_op", alu_op, 4);
    check_val("rst_decode", {alu_op, alu_src, pc_to_reg_src, imm_type, rd_src, mem_to_reg, branch}, DEC_DEF);
    check_val("rst_retire_cnt", retire_cnt, 0);
    check_val("rst_strobes", {ir_we, pc_we, reg_write, retire, illegal, dmem_req, muldiv_busy}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("release_imem_req", imem_req, 0);
    @(posedge clk);
    #1;

    // Directed: R, delayed load, branch, store, illegal, R with funct7_0.
    run_instr(32'h0000_0033, 0, 0, -1);
    run_instr(32'h0000_0003, 0, 3, -1);
    run_instr(32'h0000_0063, 0, 0, -1);
    run_instr(32'h0000_0023, 0, 0, -1);
    run_instr(32'h0000_007F, 0, 0, -1);
    run_instr(32'h0200_0033, 0, 0, -1);
    run_instr(32'h0000_006F, 2, 0, -1);
    run_instr(32'h0000_0067, 1, 0, -1);
    run_instr(32'h0000_0037, 0, 0, -1);
    run_instr(32'h0000_0017, 3, 0, -1);
    run_instr(32'h0000_0013, 0, 0, -1);

    // Random stream; enough retires to wrap the 4-bit counter several times.
    for (int i = 0; i < 80; i++) begin
      run_instr(rand_word(), $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end

    // Reset in the middle of a load's MEM phase (MEM spans cycles 3..6).
    run_instr(32'h0000_0003, 0, 3, 4);
    run_instr(32'h0000_0033, 0, 0, -1);
`ifdef MULDIV_EN
    // Reset in the middle of MULDIV.
    run_instr(32'h0200_0033, 0, 0, 4);
`endif
    for (int i = 0; i < 10; i++) begin
      run_instr(rand_word(), $urandom_range(0, 2), $urandom_range(0, 2), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the RV32I core: a parametrised, sequential successor to the single-cycle opcode decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with req/ack handshakes to instruction and data memory. It drives the existing datapath control encodings, optionally sequences a multi-cycle MUL/DIV, and counts retired instructions.

## Interface
Parameters:
- MULDIV_LAT, 4, execute cycles for a MUL/DIV op (>=1); used only with MULDIV_EN
- CNT_W, 32, width of retire counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instruction[6:0] from the instruction register
- funct7_0  in  1  instruction[25] (M-extension select)
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid; loads the IR
- dmem_req  out  1  data access request
- dmem_ack  in  1  data access complete
- ir_we  out  1  instruction register write strobe
- pc_we  out  1  PC update strobe
- alu_op  out  3  0 R, 1 I-arith, 2 branch, 3 LUI, 4 add/pass
- alu_src  out  1  1 = rs2, 0 = immediate
- pc_to_reg_src  out  1  1 = PC-relative operand (branch, AUIPC)
- imm_type  out  3  0 I, 1 S, 2 B, 3 U, 4 J, 5 none
- rd_src  out  1  1 = PC-derived writeback (JAL, JALR, AUIPC, branch)
- mem_to_reg  out  1  1 = ALU result, 0 = memory data
- mem_read  out  1  load in progress
- mem_write  out  1  store in progress
- reg_write  out  1  register file write strobe
- branch  out  2  0 none, 1 JALR, 2 conditional, 3 JAL
- muldiv_busy  out  1  MUL/DIV executing
- illegal  out  1  unsupported opcode pulse
- retire  out  1  instruction-complete pulse
- retire_cnt  out  CNT_W  retired-instruction count

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, MULDIV.
- FETCH: imem_req=1 until imem_ack. On ack: ir_we=1 for 1 cycle, then DECODE.
- DECODE: registers all decode outputs from opcode. Opcodes: 0110011 R, 0000011 load, 0010011 I-arith, 1100111 JALR, 0100011 store, 1100011 branch, 0010111 AUIPC, 0110111 LUI, 1101111 JAL. Values follow the port encodings above; ALU source is rs2 only for R and branch.
- DECODE, illegal opcode: illegal=1, pc_we=1 (skip), no retire, next FETCH. Decode outputs load their default values.
- EXEC, load/store: next MEM.
- EXEC, branch: pc_we=1, retire=1, next FETCH.
- EXEC, R-type with funct7_0=1 (MULDIV_EN only): next MULDIV.
- EXEC, all others: next WB.
- MEM: dmem_req=1 with mem_read or mem_write held until dmem_ack.
- MEM on ack, load: next WB.
- MEM on ack, store: pc_we=1, retire=1, next FETCH.
- MULDIV: muldiv_busy=1. A down-counter loads MULDIV_LAT-1 on entry; at 0, next WB.
- WB: reg_write=1, pc_we=1, retire=1, next FETCH.
- Decode outputs are stable from DECODE+1 until the next DECODE.
- mem_read and mem_write are only high in MEM. reg_write is only high in WB.
- retire_cnt increments on every retire and wraps from all-ones to 0.
- imem_ack outside FETCH and dmem_ack outside MEM are ignored.

## Timing
- Reset (async, immediate): state FETCH, alu_op=4, retire_cnt=0, all other outputs 0. After reset release, imem_req=1 on the first clock.
- Latencies with zero-wait ack (ack in the same cycle as req):
  - branch: 3 cycles
  - ALU, LUI, AUIPC, JAL, JALR, store: 4 cycles
  - load: 5 cycles
  - MUL/DIV: 4+MULDIV_LAT cycles
- Each cycle of ack delay adds 1 cycle.
- Strobes (ir_we, pc_we, reg_write, retire, illegal) are 1-cycle pulses.
- req stays high while waiting for ack, and drops the cycle after ack.
- Reset asserted mid-MEM or mid-MULDIV aborts the operation. dmem_req and muldiv_busy go low asynchronously, and the instruction does not retire.

## Configuration
- MULDIV_EN defined: the MULDIV state, its counter and muldiv_busy are present. R-type with funct7_0=1 is routed through MULDIV.
- MULDIV_EN undefined:
  - MULDIV state, counter and MULDIV_LAT are absent.
  - funct7_0 is ignored.
  - muldiv_busy is tied to 0.
  - All R-type instructions take the 4-cycle path.

## Test plan
- Reset, then opcode 0110011 with immediate acks -> imem_req cycle 0, ir_we 0, reg_write and retire at cycle 3; alu_op=0, alu_src=1, imm_type=5; retire_cnt=1.
- Load 0000011 with dmem_ack delayed 3 cycles -> mem_read and dmem_req high for 4 cycles; reg_write at cycle 7; mem_to_reg=0.
- Branch 1100011 then store 0100011 -> branch: pc_we at cycle 2, no reg_write; store: mem_write in MEM, no reg_write; retire_cnt=2.
- Opcode 1111111 -> illegal=1 and pc_we=1 in DECODE; retire=0; retire_cnt unchanged; FETCH next cycle.
- MULDIV_EN, MULDIV_LAT=4, R-type with funct7_0=1 -> muldiv_busy high for 4 cycles; reg_write at cycle 7. Without the macro: reg_write at cycle 3.
- CNT_W=4: 16 retires wrap retire_cnt to 0. rst_n low during MEM -> dmem_req=0 immediately; retire_cnt=0; FETCH after release.
